cmd_uart_wrapper: RTL

- DUT-side counterpart of the host's 16-bit command sender.
- Receives two UART bytes, high byte first then low byte, and assembles them into a 16-bit command with a sticky cmd_rdy flag for the command processor.
- Forwards the processor's 8-bit response (e.g. ack 8'hA5) out over the same UART.
- Sits between the RX/TX pins and the command processor.

---
 rtl/cmd_uart_pkg.sv | 6 +
 rtl/cmd_uart_wrapper_uart.sv | 95 +++++++++
 rtl/cmd_uart_wrapper.sv | 99 +++++++++
 3 files changed

// File: rtl/cmd_uart_pkg.sv
// cmd_uart_pkg: shared types and constants for the 16-bit command UART wrapper.
package cmd_uart_pkg;
    typedef enum logic [0:0] {HIGH = 1'b0, LOW = 1'b1} rx_state_t;
    localparam logic [7:0] RESP_ACK        = 8'hA5;
    localparam int         TIMEOUT_CYC_DEF = 1_000_000;
endpackage

// File: rtl/cmd_uart_wrapper_uart.sv
// cmd_uart_wrapper_uart: 8N1 UART transceiver; rx_rdy stays set until cleared or a new frame starts.
module cmd_uart_wrapper_uart #(
    parameter int BAUD_DIV = 434
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic [7:0] i_tx_data,
    input  logic       i_trmt,
    output logic       o_tx_done,
    output logic [7:0] o_rx_data,
    output logic       o_rx_rdy,
    input  logic       i_clr_rx_rdy
);
    localparam int BW = $clog2(BAUD_DIV);

    logic [9:0]    r_tx_shift;
    logic [BW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bits;
    logic          r_tx_busy, r_tx_done;
    logic          w_tx_tick;

    assign w_tx_tick = r_tx_busy && (r_tx_baud == BW'(BAUD_DIV - 1));
    assign o_tx      = r_tx_shift[0];
    assign o_tx_done = r_tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '1;
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= !i_trmt && w_tx_tick && (r_tx_bits == 4'd9);
            if (i_trmt) begin
                r_tx_shift <= {1'b1, i_tx_data, 1'b0};
                r_tx_baud  <= '0;
                r_tx_bits  <= '0;
                r_tx_busy  <= 1'b1;
            end else if (w_tx_tick) begin
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_baud  <= '0;
                r_tx_bits  <= r_tx_bits + 4'd1;
                r_tx_busy  <= (r_tx_bits != 4'd9);
            end else if (r_tx_busy) begin
                r_tx_baud <= r_tx_baud + BW'(1);
            end
        end
    end

    logic [2:0]    r_rx_sync;
    logic [9:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic [BW-1:0] r_rx_baud;
    logic [3:0]    r_rx_bits;
    logic          r_rx_busy, r_rx_rdy;
    logic          w_rx_start, w_rx_sample, w_rx_done;

    assign w_rx_start  = !r_rx_busy && r_rx_sync[2] && !r_rx_sync[1];
    assign w_rx_sample = r_rx_busy && (r_rx_baud == '0);
    assign w_rx_done   = w_rx_sample && (r_rx_bits == 4'd9);
    assign o_rx_data   = r_rx_data;
    assign o_rx_rdy    = r_rx_rdy;

    // First sample lands half a bit into the start bit, then once per bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync  <= '1;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_busy  <= 1'b0;
            r_rx_rdy   <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[1:0], i_rx};
            r_rx_rdy  <= w_rx_done ? 1'b1 : (i_clr_rx_rdy || w_rx_start) ? 1'b0 : r_rx_rdy;
            if (w_rx_start) begin
                r_rx_busy <= 1'b1;
                r_rx_baud <= BW'(BAUD_DIV / 2);
                r_rx_bits <= '0;
            end else if (w_rx_sample) begin
                r_rx_shift <= {r_rx_sync[1], r_rx_shift[9:1]};
                r_rx_baud  <= BW'(BAUD_DIV - 1);
                r_rx_bits  <= r_rx_bits + 4'd1;
                r_rx_busy  <= !w_rx_done;
                if (w_rx_done) r_rx_data <= r_rx_shift[9:2];
            end else if (r_rx_busy) begin
                r_rx_baud <= r_rx_baud - BW'(1);
            end
        end
    end
endmodule

// File: rtl/cmd_uart_wrapper.sv
// cmd_uart_wrapper: assembles two UART bytes (high first) into a 16-bit command and sends responses.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module cmd_uart_wrapper
    import cmd_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = 20
`endif
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        tx_done,
    output logic        timeout_err
);
    logic [7:0]  w_rx_data;
    logic        w_rx_rdy, w_clr_rx_rdy;
    rx_state_t   r_state;
    logic [7:0]  r_high_byte;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;

    cmd_uart_wrapper_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (RX),
        .o_tx         (TX),
        .i_tx_data    (resp),
        .i_trmt       (trmt),
        .o_tx_done    (tx_done),
        .o_rx_data    (w_rx_data),
        .o_rx_rdy     (w_rx_rdy),
        .i_clr_rx_rdy (w_clr_rx_rdy)
    );

    // Every received byte is consumed the cycle it is seen, in either state.
    assign w_clr_rx_rdy = w_rx_rdy;
    assign cmd          = r_cmd;
    assign cmd_rdy      = r_cmd_rdy;

`ifdef CMD_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HIGH;
            r_high_byte <= '0;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_cmd_rdy <= (r_state == LOW && w_rx_rdy) ? 1'b1 :
                         (clr_cmd_rdy || (r_state == HIGH && w_rx_rdy)) ? 1'b0 : r_cmd_rdy;
`ifdef CMD_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                HIGH: if (w_rx_rdy) begin
                    r_high_byte <= w_rx_data;
                    r_state     <= LOW;
`ifdef CMD_TIMEOUT_EN
                    r_to_cnt    <= '0;
`endif
                end
                LOW: if (w_rx_rdy) begin
                    r_cmd   <= {r_high_byte, w_rx_data};
                    r_state <= HIGH;
                end
`ifdef CMD_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    r_state       <= HIGH;
                    r_high_byte   <= '0;
                    r_timeout_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
`endif
                default: r_state <= HIGH;
            endcase
        end
    end
endmodule
